// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the penalty shoot-out flow controller
//   game_state_t : 3-bit screen/flow state consumed by screen_selector
//   WIN_*        : winner encodings driven in END
//   DEF_*        : default timing constants for a 65 MHz pixel clock
//   cnt_width    : counter width able to hold 0..max_val (never below 1)
package game_pkg;

  typedef enum logic [2:0] {
    START   = 3'd0,
    SHOOT_A = 3'd1,
    SHOOT_B = 3'd2,
    RESULT  = 3'd3,
    END     = 3'd4
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int DEF_RESULT_HOLD = 65_000_000;
  localparam int DEF_CLICK_GUARD = 6_500_000;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/click_filter.sv
// rtl/click_filter.sv - click rising-edge detector with a post-transition guard window
//   clk          : system clock
//   rst          : asynchronous reset, active-high (guard loads CLICK_GUARD)
//   left_clicked : raw mouse button level, synchronous to clk
//   restart      : high in the cycle a state change is being committed; reloads the guard
//   click_evt    : rising edge of the registered level while the guard is zero
module click_filter
  import game_pkg::*;
#(
  parameter int CLICK_GUARD = DEF_CLICK_GUARD
) (
  input  logic clk,
  input  logic rst,
  input  logic left_clicked,
  input  logic restart,
  output logic click_evt
);

  localparam int GW = cnt_width(CLICK_GUARD);
  localparam logic [GW-1:0] GUARD_INIT = GW'(CLICK_GUARD);

  logic          lvl_q, lvl_d;
  logic          prev_q, prev_d;
  logic [GW-1:0] guard_q, guard_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q   <= 1'b0;
      prev_q  <= 1'b0;
      guard_q <= GUARD_INIT;
    end else begin
      lvl_q   <= lvl_d;
      prev_q  <= prev_d;
      guard_q <= guard_d;
    end
  end

  always_comb begin
    lvl_d   = left_clicked;
    prev_d  = lvl_q;
    guard_d = guard_q;
    if (restart) begin
      guard_d = GUARD_INIT;
    end else if (guard_q != '0) begin
      guard_d = guard_q - 1'b1;
    end
  end

  // Edge detection runs even while masked, so a button held down across the
  // guard expiry has already consumed its edge and yields no event.
  assign click_evt = lvl_q & ~prev_q & (guard_q == '0);

endmodule

// File: rtl/game_flow_ctl.sv
// rtl/game_flow_ctl.sv - penalty shoot-out sequencer: regulation, early decision, sudden death
//   clk, rst          : 65 MHz clock, asynchronous active-high reset
//   left_clicked      : raw mouse level; clicks advance START, RESULT (skip) and END
//   solo_enable       : mode request, latched into solo when leaving START
//   shot_valid        : one-cycle pulse, current shot resolved (SHOOT_A/SHOOT_B only)
//   shot_goal         : qualifies shot_valid, 1 = goal
//   state             : game_state_t
//   round             : 1-based round, 0 in START
//   score_a, score_b  : goals per side
//   solo              : latched mode for this game
//   sudden_death      : round > N_ROUNDS
//   winner            : WIN_* code, meaningful in END
//   last_goal         : shot_goal of the most recent resolved shot
//   state_chg         : one-cycle pulse in the first cycle of every new state
module game_flow_ctl
  import game_pkg::*;
#(
  parameter int N_ROUNDS    = 5,
  parameter int MAX_SD      = 10,
  parameter int RND_W       = 5,
  parameter int SCORE_W     = 5,
  parameter int RESULT_HOLD = DEF_RESULT_HOLD,
  parameter int CLICK_GUARD = DEF_CLICK_GUARD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               left_clicked,
  input  logic               solo_enable,
  input  logic               shot_valid,
  input  logic               shot_goal,
  output logic [2:0]         state,
  output logic [RND_W-1:0]   round,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               solo,
  output logic               sudden_death,
  output logic [1:0]         winner,
  output logic               last_goal,
  output logic               state_chg
);

  localparam int HW = cnt_width(RESULT_HOLD);
  localparam int CW = ((SCORE_W > RND_W) ? SCORE_W : RND_W) + 1;
  localparam logic [RND_W-1:0] ROUND_REG = RND_W'(N_ROUNDS);
  localparam logic [RND_W-1:0] ROUND_CAP = RND_W'(N_ROUNDS + MAX_SD);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RESULT_HOLD - 1);

  game_state_t        state_q, state_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic               solo_q, solo_d;
  logic               sd_q, sd_d;
  logic [1:0]         winner_q, winner_d;
  logic               last_goal_q, last_goal_d;
  logic               state_chg_q, state_chg_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               shot_b_q, shot_b_d;   // 1 = last resolved shot was B's

  logic               click_evt;
  logic [CW-1:0]      sa_x, sb_x, rem_a, rem_b, left_reg;
  logic               a_clinch, b_clinch, decide_ok;

  click_filter #(
    .CLICK_GUARD (CLICK_GUARD)
  ) u_click_filter (
    .clk          (clk),
    .rst          (rst),
    .left_clicked (left_clicked),
    .restart      (state_chg_d),
    .click_evt    (click_evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= START;
      round_q     <= '0;
      score_a_q   <= '0;
      score_b_q   <= '0;
      solo_q      <= 1'b0;
      sd_q        <= 1'b0;
      winner_q    <= WIN_NONE;
      last_goal_q <= 1'b0;
      state_chg_q <= 1'b0;
      hold_q      <= '0;
      shot_b_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      score_a_q   <= score_a_d;
      score_b_q   <= score_b_d;
      solo_q      <= solo_d;
      sd_q        <= sd_d;
      winner_q    <= winner_d;
      last_goal_q <= last_goal_d;
      state_chg_q <= state_chg_d;
      hold_q      <= hold_d;
      shot_b_q    <= shot_b_d;
    end
  end

  // Remaining-shot bounds. In sudden death both are zero, so a clinch is
  // simply a strict lead, and it is only acted on after B has shot.
  always_comb begin
    sa_x     = CW'(score_a_q);
    sb_x     = CW'(score_b_q);
    left_reg = CW'(ROUND_REG) - CW'(round_q);
    if (sd_q) begin
      rem_a = '0;
      rem_b = '0;
    end else begin
      rem_a = left_reg;
      rem_b = shot_b_q ? left_reg : left_reg + CW'(1);
    end
    a_clinch  = sa_x > (sb_x + rem_b);
    b_clinch  = sb_x > (sa_x + rem_a);
    decide_ok = !sd_q || shot_b_q;
  end

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    solo_d      = solo_q;
    winner_d    = winner_q;
    last_goal_d = last_goal_q;
    hold_d      = '0;
    shot_b_d    = shot_b_q;

    case (state_q)
      START: begin
        if (click_evt) begin
          state_d   = SHOOT_A;
          round_d   = RND_W'(1);
          score_a_d = '0;
          score_b_d = '0;
          solo_d    = solo_enable;
          winner_d  = WIN_NONE;
        end
      end
      SHOOT_A: begin
        if (shot_valid) begin
          state_d     = RESULT;
          score_a_d   = score_a_q + SCORE_W'(shot_goal);
          last_goal_d = shot_goal;
          shot_b_d    = 1'b0;
        end
      end
      SHOOT_B: begin
        if (shot_valid) begin
          state_d     = RESULT;
          score_b_d   = score_b_q + SCORE_W'(shot_goal);
          last_goal_d = shot_goal;
          shot_b_d    = 1'b1;
        end
      end
      RESULT: begin
        // A click after the guard ends the hold early with the same decision.
        if (hold_q == HOLD_LAST || click_evt) begin
          if (decide_ok && a_clinch) begin
            state_d  = END;
            winner_d = WIN_A;
          end else if (decide_ok && b_clinch) begin
            state_d  = END;
            winner_d = WIN_B;
          end else if (!shot_b_q) begin
            state_d = SHOOT_B;
          end else if (round_q < ROUND_CAP) begin
            state_d = SHOOT_A;
            round_d = round_q + RND_W'(1);
          end else begin
            state_d  = END;
            winner_d = WIN_DRAW;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      END: begin
        if (click_evt) begin
          state_d   = START;
          round_d   = '0;
          score_a_d = '0;
          score_b_d = '0;
          winner_d  = WIN_NONE;
        end
      end
      default: state_d = START;
    endcase

    sd_d        = round_d > ROUND_REG;
    state_chg_d = state_d != state_q;
  end

  always_comb begin
    state        = state_q;
    round        = round_q;
    score_a      = score_a_q;
    score_b      = score_b_q;
    solo         = solo_q;
    sudden_death = sd_q;
    winner       = winner_q;
    last_goal    = last_goal_q;
    state_chg    = state_chg_q;
  end

endmodule

// File: tb/tb_game_flow_ctl.sv
// tb/tb_game_flow_ctl.sv - scoreboard bench for game_flow_ctl (N=5, MAX_SD=1, hold 20, guard 4)
module tb_game_flow_ctl;
  import game_pkg::*;

  localparam int HOLD = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left_clicked = 1'b0;
  logic       solo_enable = 1'b0;
  logic       shot_valid = 1'b0;
  logic       shot_goal = 1'b0;
  logic [2:0] state;
  logic [4:0] round, score_a, score_b;
  logic       solo, sudden_death, last_goal, state_chg;
  logic [1:0] winner;

  game_flow_ctl #(
    .N_ROUNDS(5), .MAX_SD(1), .RND_W(5), .SCORE_W(5),
    .RESULT_HOLD(HOLD), .CLICK_GUARD(4)
  ) dut (
    .clk(clk), .rst(rst), .left_clicked(left_clicked), .solo_enable(solo_enable),
    .shot_valid(shot_valid), .shot_goal(shot_goal), .state(state), .round(round),
    .score_a(score_a), .score_b(score_b), .solo(solo), .sudden_death(sudden_death),
    .winner(winner), .last_goal(last_goal), .state_chg(state_chg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] rnd;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [1:0] win;
    logic       lg;
    logic       sd;
    logic       solo;
  } snap_t;

  snap_t exp_q[$];
  snap_t m_act, m_exp;
  int    cur_round = 0;
  bit    cur_lg = 1'b0;
  bit    cur_solo = 1'b0;

  function automatic snap_t mk(input logic [2:0] st, input int rnd, input int sa, input int sb,
                               input logic [1:0] win, input bit lg, input bit so);
    snap_t s;
    s.st = st; s.rnd = 5'(rnd); s.sa = 5'(sa); s.sb = 5'(sb);
    s.win = win; s.lg = lg; s.sd = (rnd > 5); s.solo = so;
    return s;
  endfunction

  // Monitor: every state_chg pulse must match the oldest expected transition.
  always @(negedge clk) begin
    if (!rst && state_chg === 1'b1) begin
      checks++;
      m_act = '{st: state, rnd: round, sa: score_a, sb: score_b, win: winner,
                lg: last_goal, sd: sudden_death, solo: solo};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_transition state=%0d round=%0d a=%0d b=%0d", state, round, score_a, score_b);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_act !== m_exp) begin
          failures++;
          $display("FAIL transition st/rnd/a/b/win/lg/sd/solo got %0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d",
                   m_act.st, m_act.rnd, m_act.sa, m_act.sb, m_act.win, m_act.lg, m_act.sd, m_act.solo,
                   m_exp.st, m_exp.rnd, m_exp.sa, m_exp.sb, m_exp.win, m_exp.lg, m_exp.sd, m_exp.solo);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      idle(1);
      n++;
    end
    check("wait_state", state, s);
  endtask

  task automatic click_pulse();
    left_clicked = 1'b1;
    idle(1);
    left_clicked = 1'b0;
  endtask

  task automatic start_game(input bit so);
    solo_enable = so;
    exp_q.push_back(mk(SHOOT_A, 1, 0, 0, WIN_NONE, cur_lg, so));
    click_pulse();
    wait_state(SHOOT_A, 10);
    cur_round = 1;
    cur_solo = so;
  endtask

  task automatic end_game();
    exp_q.push_back(mk(START, 0, 0, 0, WIN_NONE, cur_lg, cur_solo));
    click_pulse();
    wait_state(START, 10);
    cur_round = 0;
    idle(6);
  endtask

  // mode 0: plain hold, 1: extra shot_valid inside RESULT, 2: click skips the hold
  task automatic shot(input bit goal, input logic [2:0] ns, input int nr, input int ea, input int eb,
                      input logic [1:0] w, input int mode);
    int t0;
    int n;
    exp_q.push_back(mk(RESULT, cur_round, ea, eb, WIN_NONE, goal, cur_solo));
    exp_q.push_back(mk(ns, nr, ea, eb, w, goal, cur_solo));
    shot_valid = 1'b1;
    shot_goal = goal;
    idle(1);
    shot_valid = 1'b0;
    shot_goal = 1'b0;
    t0 = cyc;
    if (mode == 1) begin
      idle(2);
      shot_valid = 1'b1;
      shot_goal = 1'b1;
      idle(1);
      shot_valid = 1'b0;
      shot_goal = 1'b0;
    end else if (mode == 2) begin
      idle(6);
      click_pulse();
    end
    n = 0;
    while (state === RESULT && n < 60) begin
      idle(1);
      n++;
    end
    if (mode == 2) check("skip_latency", cyc - t0, 8);
    else           check("result_hold", cyc - t0, HOLD);
    cur_round = nr;
    cur_lg = goal;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_state", state, START);
    check("rst_round", round, 0);
    check("rst_score_a", score_a, 0);
    check("rst_score_b", score_b, 0);
    check("rst_winner", winner, WIN_NONE);
    check("rst_solo", solo, 0);
    check("rst_sd", sudden_death, 0);
    check("rst_last_goal", last_goal, 0);
    check("rst_state_chg", state_chg, 0);

    // Click inside the post-reset guard window is dropped.
    idle(1);
    click_pulse();
    idle(8);
    check("early_click_ignored", state, START);

    // Game 1: regulation, A wins 3:2 after B's round-5 shot.
    start_game(1'b0);
    check("chg_pulse_hi", state_chg, 1);
    idle(1);
    check("chg_pulse_lo", state_chg, 0);
    shot(1, SHOOT_B, 1, 1, 0, WIN_NONE, 0);
    shot(0, SHOOT_A, 2, 1, 0, WIN_NONE, 0);
    shot(0, SHOOT_B, 2, 1, 0, WIN_NONE, 0);
    shot(1, SHOOT_A, 3, 1, 1, WIN_NONE, 0);
    shot(1, SHOOT_B, 3, 2, 1, WIN_NONE, 0);
    shot(0, SHOOT_A, 4, 2, 1, WIN_NONE, 0);
    shot(0, SHOOT_B, 4, 2, 1, WIN_NONE, 0);
    shot(1, SHOOT_A, 5, 2, 2, WIN_NONE, 0);
    shot(1, SHOOT_B, 5, 3, 2, WIN_NONE, 0);
    shot(0, END, 5, 3, 2, WIN_A, 0);
    // Level raised inside the guard and held past expiry: no event.
    left_clicked = 1'b1;
    idle(10);
    left_clicked = 1'b0;
    idle(2);
    check("held_click_ignored", state, END);
    // shot_valid in END must not touch last_goal.
    shot_valid = 1'b1;
    shot_goal = 1'b1;
    idle(1);
    shot_valid = 1'b0;
    shot_goal = 1'b0;
    end_game();

    // Game 2: early decision 3:0 after B's 3rd shot; stray shots; click skip.
    shot_valid = 1'b1;
    shot_goal = 1'b1;
    idle(1);
    shot_valid = 1'b0;
    shot_goal = 1'b0;
    start_game(1'b1);
    shot(1, SHOOT_B, 1, 1, 0, WIN_NONE, 1);
    shot(0, SHOOT_A, 2, 1, 0, WIN_NONE, 0);
    shot(1, SHOOT_B, 2, 2, 0, WIN_NONE, 2);
    shot(0, SHOOT_A, 3, 2, 0, WIN_NONE, 0);
    shot(1, SHOOT_B, 3, 3, 0, WIN_NONE, 0);
    shot(0, END, 3, 3, 0, WIN_A, 0);
    idle(6);
    end_game();

    // Game 3: 4:4 after regulation, A wins in sudden death round 6.
    start_game(1'b0);
    for (int r = 1; r <= 4; r++) begin
      shot(1, SHOOT_B, r, r, r - 1, WIN_NONE, 0);
      shot(1, SHOOT_A, r + 1, r, r, WIN_NONE, 0);
    end
    shot(0, SHOOT_B, 5, 4, 4, WIN_NONE, 0);
    shot(0, SHOOT_A, 6, 4, 4, WIN_NONE, 0);
    check("sd_round6", sudden_death, 1);
    shot(1, SHOOT_B, 6, 5, 4, WIN_NONE, 0);
    shot(0, END, 6, 5, 4, WIN_A, 0);
    idle(6);
    end_game();

    // Game 4: tied through the sudden-death cap -> draw.
    start_game(1'b0);
    for (int r = 1; r <= 5; r++) begin
      shot(0, SHOOT_B, r, 0, 0, WIN_NONE, 0);
      shot(0, SHOOT_A, r + 1, 0, 0, WIN_NONE, 0);
    end
    shot(0, SHOOT_B, 6, 0, 0, WIN_NONE, 0);
    shot(0, END, 6, 0, 0, WIN_DRAW, 0);
    check("draw_winner", winner, WIN_DRAW);
    idle(6);
    end_game();

    // Game 5: asynchronous reset while RESULT shows 2:1.
    start_game(1'b0);
    shot(1, SHOOT_B, 1, 1, 0, WIN_NONE, 0);
    shot(1, SHOOT_A, 2, 1, 1, WIN_NONE, 0);
    exp_q.push_back(mk(RESULT, 2, 2, 1, WIN_NONE, 1, 0));
    shot_valid = 1'b1;
    shot_goal = 1'b1;
    idle(1);
    shot_valid = 1'b0;
    shot_goal = 1'b0;
    idle(5);
    check("pre_rst_score_a", score_a, 2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_state", state, START);
    check("mid_rst_score_a", score_a, 0);
    check("mid_rst_score_b", score_b, 0);
    check("mid_rst_round", round, 0);
    check("mid_rst_winner", winner, WIN_NONE);
    idle(2);
    rst = 1'b0;
    idle(30);
    check("post_rst_state", state, START);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_flow_ctl.md
Name: game_flow_ctl

Overview:
Parametrised successor to the current game state selector. It sequences a full penalty shoot-out, replacing the click-only menu toggle:
- N regulation rounds, A shoots then B in each round.
- Early-decision termination.
- Sudden death with a cap.
- Click rising-edge detection with a post-transition guard window.

It sits between MouseCtl/gameplay logic and screen_selector, and drives the state, round and score values that screen_selector and the overlay renderers consume.

Parameters:
N_ROUNDS, 5, regulation rounds (>=1)
MAX_SD, 10, maximum sudden-death rounds before a forced draw
RND_W, 5, round counter width; must hold N_ROUNDS+MAX_SD
SCORE_W, 5, score width; must hold N_ROUNDS+MAX_SD
RESULT_HOLD, 65_000_000, clk cycles the RESULT state is held (1 s at 65 MHz)
CLICK_GUARD, 6_500_000, clk cycles after any state change during which clicks are ignored

Ports:
clk  in  1  system clock (65 MHz pixel clock)
rst  in  1  asynchronous reset, active-high
left_clicked  in  1  raw level from MouseCtl, synchronous to clk
solo_enable  in  1  1 = player vs CPU, 0 = two players; sampled only on START exit
shot_valid  in  1  one-cycle pulse from gameplay: current shot resolved
shot_goal  in  1  qualifies shot_valid: 1 = goal
state  out  3  game_state_t: START, SHOOT_A, SHOOT_B, RESULT, END
round  out  RND_W  current round, 1-based; 0 in START
score_a  out  SCORE_W  goals by side A (player 1)
score_b  out  SCORE_W  goals by side B (CPU or player 2)
solo  out  1  latched mode for this game
sudden_death  out  1  high while round > N_ROUNDS
winner  out  2  valid in END: 01 = A, 10 = B, 11 = draw (cap reached), 00 otherwise
last_goal  out  1  shot_goal of the most recent resolved shot
state_chg  out  1  one-cycle pulse on every state transition

Behaviour:
- Reset values: state=START, round=0, score_a=score_b=0, solo=0, sudden_death=0, winner=00, last_goal=0, state_chg=0, guard counter loaded with CLICK_GUARD, hold counter=0.
- Click event: rising edge of the registered left_clicked, masked while the guard counter is non-zero. The guard reloads on every state change and decrements to 0. A level held across the guard expiry produces no event.
- START: click -> SHOOT_A; round<=1; scores cleared; solo<=solo_enable.
- SHOOT_A / SHOOT_B: shot_valid -> RESULT next cycle. The matching score increments in the same edge if shot_goal=1. last_goal is updated. The shooter is remembered.
- shot_valid outside SHOOT_A/SHOOT_B is ignored. Clicks in SHOOT states are ignored by this block.
- RESULT: hold counter counts RESULT_HOLD cycles; on expiry, the decision is evaluated with post-shot scores:
  - regulation, after A's shot: rem_a = N_ROUNDS-round, rem_b = N_ROUNDS-round+1.
  - regulation, after B's shot: rem_a = rem_b = N_ROUNDS-round.
  - If score_a > score_b+rem_b -> END, winner=01. If score_b > score_a+rem_a -> END, winner=10.
  - Otherwise, after A's shot -> SHOOT_B.
  - Otherwise, after B's shot: if round < N_ROUNDS+MAX_SD -> round+1, SHOOT_A. If the cap is reached -> END, winner=11.
  - Sudden death: decision only after B's shot; a score difference -> END with the leader as winner.
- A click during RESULT after the guard skips the remaining hold (same-cycle evaluation).
- END: click -> START. round, scores and winner are cleared on entering START.
- sudden_death = (round > N_ROUNDS), registered alongside round.
- All outputs are registered; state_chg is asserted the cycle state takes its new value.
- Score/round arithmetic is unsigned, with no saturation needed given the parameter constraints.
- Comparisons are done at SCORE_W+1 bits to avoid overflow.
- Reset mid-game returns to reset values immediately (asynchronous); no pending shot is retained.

Decomposition:
- game_pkg: game_state_t enum (3-bit), winner encodings (WIN_NONE/A/B/DRAW), default timing constants.
- Sub-module click_filter: edge detection plus guard counter. Inputs clk, rst, left_clicked, restart; output click_evt. Parameter CLICK_GUARD.
- The FSM, counters and decision logic stay in game_flow_ctl.

Test Plan:
(Bench uses RESULT_HOLD=20, CLICK_GUARD=4.)
- Reset mid-RESULT with score 2:1 -> state=START, scores 0, round 0, winner 00 within the reset assertion.
- Click at cycle 2 after reset -> ignored. Click after 4 guard cycles -> SHOOT_A, round=1, state_chg single pulse.
- Regulation N=5 with goals A:3, B:2, decided in round 5 after B's shot -> END, winner=01, round=5.
- Early decision: A scores rounds 1-3, B misses rounds 1-3 -> END after B's 3rd shot (3 > 0+2), winner=01.
- Sudden death: 5 rounds tied 4:4; round 6 A goal, B miss -> sudden_death=1 in round 6, END, winner=01. With MAX_SD=1 and round 6 tied -> winner=11.
- shot_valid pulsed in RESULT/START is ignored, scores unchanged. Click in RESULT after guard skips the hold -> SHOOT_B next cycle.
